if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage feeding the IF/ID pipeline register. Owns the program counter, fetches from instruction memory over a req/ack handshake with at most one request outstanding, buffers up to two fetched words in a prefetch queue, and presents one instruction per cycle to IF/ID. It obeys the hazard-unit stall (`hd_i`) and taken-branch redirects from ID, and drives IF/ID's flush input whenever no valid instruction is available or a redirect occurs.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk_i`  in  1: clock, all state on rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `hd_i`  in  1: stall from hazard detection; IF/ID holds, nothing is consumed.
- `branch_i`  in  1: taken branch/jump resolved in ID.
- `branch_addr_i`  in  32: redirect target, valid with `branch_i`.
- `imem_req_o`  out  1: fetch request.
- `imem_addr_o`  out  32: fetch address, stable while `imem_req_o`=1.
- `imem_ack_i`  in  1: memory returns `imem_data_i` this cycle; may coincide with the first request cycle.
- `imem_data_i`  in  32: fetched instruction word.
- `inst_o`  out  32: instruction to IF/ID.
- `inst_addr_o`  out  32: PC+4 of `inst_o`, to IF/ID.
- `flush_o`  out  1: to IF/ID flush input.

## Operation
- Registers: `pc` (next address to issue), `req_addr`, state, 2-entry queue of {inst, pc4}, `count` (0..2).
- `take` = `branch_i` & !`hd_i`; `pop` = (`count`>0) & !`hd_i` & !`take`; `push` = `imem_ack_i` & state==WAIT.
- Issue: `req_addr`←`pc`, `pc`←`pc`+4, state←WAIT. Ack pushes {`imem_data_i`, `req_addr`+4}.
- States: IDLE (no request), WAIT (request live, data kept), DISCARD (request live, data dropped).
- Transitions, first match wins:
  - `take`, request live and no ack: queue cleared, `pc`←`branch_addr_i`, state←DISCARD.
  - `take` otherwise: queue cleared; issue from `branch_addr_i` (`req_addr`←target, `pc`←target+4), state←WAIT.
  - DISCARD & ack: data dropped; issue from `pc`.
  - WAIT & ack: push; issue if `count_next`<2, else state←IDLE.
  - IDLE: issue if `count_next`<2.
- `count_next` = `count` + `push` − `pop`. Issue only when `count_next`<2 guarantees queue + outstanding ≤ 2; a push never meets a full queue.
- `imem_req_o`=1 in WAIT and DISCARD; `imem_addr_o`=`req_addr`.
- `inst_o`/`inst_addr_o` = queue head when `count`>0; else NOP 32'hFC00_0000 and 32'h0.
- `flush_o` = (`count`==0) | `branch_i`.
- `hd_i`=1: no pop, no redirect; fetching continues until queue + outstanding = 2.

## Timing
- Reset: state IDLE, `count`=0, `pc`=`req_addr`=`RESET_PC`; `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `inst_o`=32'hFC00_0000, `inst_addr_o`=0, `flush_o`=1.
- Reset asserted mid-request: request dropped immediately; memory must tolerate abandoned requests.
- Zero-wait memory: edge 1 after reset release issues `RESET_PC`; edge 2 pushes it and issues +4; IF/ID captures the first instruction at edge 3. Throughput afterwards is 1 instruction/cycle.
- Fetch outputs are combinational from registered state only; `flush_o` also depends on `branch_i`.
- Redirect-to-first-target-instruction latency with zero-wait memory is 2 edges; each extra memory wait cycle adds 1.
- Branch during DISCARD: only `pc` is retargeted; the live request completes and is dropped.

## Structure
- Package `if_pkg`: `NOP_INST` = 32'hFC00_0000, state enum {IDLE, WAIT, DISCARD}, `QDEPTH` = 2.
- Sub-module `fetch_fifo2`: 2-entry queue with push, pop, clear, head, and count outputs. The FSM and PC stay in `if_fetch`.

## Test plan
- Reset, zero-wait memory, `hd_i`=0: requests 0x0, 0x4, 0x8 on consecutive cycles; `inst_addr_o` = 0x4, 0x8, … one per cycle; `flush_o`=0 from cycle 2.
- `hd_i` held for 5 cycles: at most 2 words queued, `imem_req_o` drops, head stable. On release, words are delivered in order with no loss or duplication.
- 3-cycle ack latency: `imem_addr_o` stable across wait cycles; `flush_o`=1 while the queue is empty.
- `branch_i` with target 0x100 while a request is outstanding: the late ack is discarded; the next request is 0x100; the first delivered `inst_addr_o` is 0x104.
- `branch_i` together with `hd_i`=1: ignored; queue and `pc` unchanged.
- `rst_i` pulsed mid-WAIT: outputs return to reset values asynchronously; the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned QDEPTH = 2;
  localparam int unsigned CNT_W  = 2;

  localparam logic [XLEN-1:0] NOP_INST = 32'hFC00_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry prefetch queue; entry 0 is always the head.
module fetch_fifo2
  import if_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_i,
  input  logic [XLEN-1:0]   din_inst_i,
  input  logic [XLEN-1:0]   din_pc4_i,
  output logic [XLEN-1:0]   head_inst_o,
  output logic [XLEN-1:0]   head_pc4_o,
  output logic [CNT_W-1:0]  count_o
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d, din;
  logic [CNT_W-1:0] count_q, count_d;

  assign din = '{inst: din_inst_i, pc4: din_pc4_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= '0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  // Callers never push into a full queue nor pop an empty one.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == '0) e0_d = din;
          else               e1_d = din;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            e0_d = din;
          end else begin
            e0_d = e1_q;
            e1_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_inst_o = e0_q.inst;
  assign head_pc4_o  = e0_q.pc4;
  assign count_o     = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, prefetch
// queue, stall and redirect handling toward IF/ID.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hd_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        flush_o
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d, req_addr_q, req_addr_d;
  logic [CNT_W-1:0] count, count_next;
  logic [31:0]      head_inst, head_pc4;
  logic             take, pop, push, clear, req_live;

  assign take       = branch_i & ~hd_i;
  assign pop        = (count != '0) & ~hd_i & ~take;
  assign push       = imem_ack_i & (state_q == WAIT);
  assign req_live   = (state_q != IDLE);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  fetch_fifo2 u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .pop_i       (pop),
    .clear_i     (clear),
    .din_inst_i  (imem_data_i),
    .din_pc4_i   (req_addr_q + 32'd4),
    .head_inst_o (head_inst),
    .head_pc4_o  (head_pc4),
    .count_o     (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Issuing only while count_next < QDEPTH keeps queue + outstanding <= 2.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    clear      = 1'b0;
    if (take && req_live && !imem_ack_i) begin
      clear   = 1'b1;
      pc_d    = branch_addr_i;
      state_d = DISCARD;
    end else if (take) begin
      clear      = 1'b1;
      req_addr_d = branch_addr_i;
      pc_d       = branch_addr_i + 32'd4;
      state_d    = WAIT;
    end else if ((state_q == DISCARD) && imem_ack_i) begin
      req_addr_d = pc_q;
      pc_d       = pc_q + 32'd4;
      state_d    = WAIT;
    end else if (((state_q == WAIT) && imem_ack_i) || (state_q == IDLE)) begin
      if (32'(count_next) < QDEPTH) begin
        req_addr_d = pc_q;
        pc_d       = pc_q + 32'd4;
        state_d    = WAIT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    imem_req_o  = req_live;
    imem_addr_o = req_addr_q;
    inst_o      = NOP_INST;
    inst_addr_o = 32'h0;
    if (count != '0) begin
      inst_o      = head_inst;
      inst_addr_o = head_pc4;
    end
    flush_o = (count == '0) | branch_i;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: latency-configurable memory, queue-level
// reference model checked every cycle, plus hand-computed directed checks.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst, hd, branch;
  logic [31:0] branch_addr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] inst, inst_addr;
  logic        flush;

  int unsigned lat      = 0;
  int unsigned wait_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .hd_i          (hd),
    .branch_i      (branch),
    .branch_addr_i (branch_addr),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_data_i   (imem_data),
    .inst_o        (inst),
    .inst_addr_o   (inst_addr),
    .flush_o       (flush)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_3C3C;
  endfunction

  // Memory acks after `lat` wait cycles of a held request.
  assign imem_ack  = imem_req && (wait_cnt >= lat);
  assign imem_data = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pc4 values that IF/ID is still owed.
  logic [31:0] mq[$];
  logic [31:0] exp_req, prev_addr;
  bit          prev_live, discarding, m_take;

  initial begin
    exp_req    = RESET_PC;
    prev_addr  = RESET_PC;
    prev_live  = 1'b0;
    discarding = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("m_rst_req",   32'(imem_req), 32'd0);
        chk("m_rst_addr",  imem_addr, RESET_PC);
        chk("m_rst_inst",  inst, NOP);
        chk("m_rst_iaddr", inst_addr, 32'd0);
        chk("m_rst_flush", 32'(flush), 32'd1);
        mq.delete();
        exp_req    = RESET_PC;
        prev_live  = 1'b0;
        discarding = 1'b0;
      end else begin
        chk("m_inst",  inst,      (mq.size() > 0) ? mem_word(mq[0] - 32'd4) : NOP);
        chk("m_iaddr", inst_addr, (mq.size() > 0) ? mq[0] : 32'd0);
        chk("m_flush", 32'(flush), 32'((mq.size() == 0) || branch));
        chk("m_occupancy", 32'((32'(mq.size()) + 32'(imem_req)) <= 32'd2), 32'd1);
        if (imem_req) begin
          if (prev_live) chk("m_req_stable", imem_addr, prev_addr);
          else           chk("m_req_addr",   imem_addr, exp_req);
        end
        m_take = branch && !hd;
        if (m_take) begin
          mq.delete();
        end else begin
          if (!hd && mq.size() > 0) void'(mq.pop_front());
          if (imem_ack && !discarding) mq.push_back(imem_addr + 32'd4);
        end
        if (imem_ack) begin
          if (!discarding) exp_req = imem_addr + 32'd4;
          discarding = 1'b0;
        end
        if (m_take) begin
          exp_req    = branch_addr;
          discarding = imem_req && !imem_ack;
        end
        prev_live = imem_req && !imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] hd_pat, br_pat;

  initial begin
    rst = 1'b1; hd = 1'b0; branch = 1'b0; branch_addr = 32'h0;
    repeat (3) tick();
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, RESET_PC);
    chk("rst_inst",  inst, NOP);
    chk("rst_iaddr", inst_addr, 32'd0);
    chk("rst_flush", 32'(flush), 32'd1);
    rst = 1'b0;
    #1 chk("idle_req", 32'(imem_req), 32'd0);

    // Zero-wait streaming
    tick(); // edge 1
    chk("e1_req", 32'(imem_req), 32'd1);
    chk("e1_addr", imem_addr, 32'h0);
    chk("e1_flush", 32'(flush), 32'd1);
    tick(); // edge 2
    chk("e2_addr", imem_addr, 32'h4);
    chk("e2_iaddr", inst_addr, 32'h4);
    chk("e2_inst", inst, 32'h5A5A_3C3C);
    chk("e2_flush", 32'(flush), 32'd0);
    tick(); // edge 3
    chk("e3_addr", imem_addr, 32'h8);
    chk("e3_iaddr", inst_addr, 32'h8);

    // Stall for 5 cycles
    hd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hd_req", 32'(imem_req), 32'd0);
      chk("hd_head", inst_addr, 32'h8);
    end
    hd = 1'b0;
    tick(); // edge 9
    chk("rel_iaddr0", inst_addr, 32'hC);
    chk("rel_addr0", imem_addr, 32'hC);
    tick(); // edge 10
    chk("rel_iaddr1", inst_addr, 32'h10);
    chk("rel_addr1", imem_addr, 32'h10);

    // 3-cycle ack latency
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lat_req", 32'(imem_req), 32'd1);
      chk("lat_addr", imem_addr, 32'h10);
      chk("lat_flush", 32'(flush), 32'd1);
    end
    tick(); // edge 14
    chk("lat_iaddr", inst_addr, 32'h14);
    chk("lat_flush0", 32'(flush), 32'd0);
    chk("lat_next", imem_addr, 32'h14);

    // Redirect while a request is outstanding
    branch = 1'b1; branch_addr = 32'h100;
    #1 chk("br_flush", 32'(flush), 32'd1);
    tick(); // edge 15
    branch = 1'b0; lat = 0;
    chk("br_live_addr", imem_addr, 32'h14);
    chk("br_live_req", 32'(imem_req), 32'd1);
    chk("br_q_flush", 32'(flush), 32'd1);
    tick(); // edge 16
    chk("br_tgt_addr", imem_addr, 32'h100);
    chk("br_tgt_flush", 32'(flush), 32'd1);
    tick(); // edge 17
    chk("br_first_iaddr", inst_addr, 32'h104);
    chk("br_first_inst", inst, 32'h5A5A_3D3C);

    // Branch during stall is ignored
    hd = 1'b1; branch = 1'b1; branch_addr = 32'h200;
    tick(); // edge 18
    chk("brhd_iaddr0", inst_addr, 32'h104);
    chk("brhd_req0", 32'(imem_req), 32'd0);
    tick(); // edge 19
    chk("brhd_iaddr1", inst_addr, 32'h104);
    hd = 1'b0; branch = 1'b0;
    tick(); // edge 20
    chk("brhd_after_iaddr", inst_addr, 32'h108);
    chk("brhd_after_addr", imem_addr, 32'h108);

    // Asynchronous reset in the middle of a request
    lat = 5;
    tick(); // edge 21
    chk("mid_req", 32'(imem_req), 32'd1);
    chk("mid_addr", imem_addr, 32'h108);
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, RESET_PC);
    chk("arst_flush", 32'(flush), 32'd1);
    tick(); // edge 22
    lat = 0; rst = 1'b0;
    tick(); // edge 23
    chk("restart_addr", imem_addr, RESET_PC);
    chk("restart_req", 32'(imem_req), 32'd1);
    tick(); // edge 24
    chk("restart_iaddr", inst_addr, 32'h4);

    // Mixed stall / branch / latency patterns, checked by the model
    hd_pat = 32'b0110_0011_1000_0101_1100_0001_0010_0110;
    br_pat = 32'b0001_0000_0100_1000_0010_0000_1001_0000;
    for (int i = 0; i < 48; i++) begin
      hd          = hd_pat[i % 32];
      branch      = br_pat[i % 32];
      branch_addr = 32'h300 + 32'(i) * 32'h40;
      lat         = 32'(i % 3);
      tick();
    end
    hd = 1'b0; branch = 1'b0; lat = 0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
